// File: rtl/rx_core.sv
// Receive DSP path: lane sum, integrate-and-dump decimation, gain with
// saturation, and a 4-entry first-word-fall-through output FIFO.
module rx_core #(
  parameter int NUMBER_OF_LINE = 8,
  parameter int DECIM_LOG2     = 3
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         enable,
  input  logic [7:0]                   mixer_gain,
  input  logic [16*NUMBER_OF_LINE-1:0] adc_data,
  output logic [15:0]                  m_tdata,
  output logic                         m_tuser,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic                         overflow,
  input  logic                         clear_overflow
);

  localparam int L  = $clog2(NUMBER_OF_LINE);
  localparam int SW = 16 + L;
  localparam int W  = SW + DECIM_LOG2;
  localparam int PW = W + 9;
  localparam int SH = 7 + L + DECIM_LOG2;
  localparam int CW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam logic [CW-1:0]        CNT_LAST = CW'((1 << DECIM_LOG2) - 1);
  localparam logic signed [PW-1:0] MAXV     = PW'(32767);
  localparam logic signed [PW-1:0] MINV     = PW'(-32768);

  logic [16*NUMBER_OF_LINE-1:0] s0_data;
  logic                         s0_en;
  logic signed [SW-1:0]         lane_sum;
  logic signed [SW-1:0]         s1_sum;
  logic                         s1_en;
  logic signed [W-1:0]          acc;
  logic [CW-1:0]                cnt;
  logic                         dump;
  logic signed [PW-1:0]         prod;
  logic signed [PW-1:0]         y;
  logic [15:0]                  sat_data;
  logic                         sat_user;
  logic [15:0]                  s3_data;
  logic                         s3_user;
  logic                         s3_valid;

  always_comb begin
    lane_sum = '0;
    for (int unsigned i = 0; i < NUMBER_OF_LINE; i++) begin
      lane_sum = lane_sum + SW'($signed(s0_data[16*i +: 16]));
    end
  end

  always_comb begin
    prod     = PW'(acc) * PW'($signed({1'b0, mixer_gain}));
    y        = prod >>> SH;
    sat_data = y[15:0];
    sat_user = 1'b0;
    if (y > MAXV) begin
      sat_data = 16'h7fff;
      sat_user = 1'b1;
    end else if (y < MINV) begin
      sat_data = 16'h8000;
      sat_user = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s0_data  <= '0;
      s0_en    <= 1'b0;
      s1_sum   <= '0;
      s1_en    <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      dump     <= 1'b0;
      s3_data  <= '0;
      s3_user  <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      s0_data <= adc_data;
      s0_en   <= enable;
      s1_sum  <= lane_sum;
      s1_en   <= s0_en;
      // A disabled sample holds the counter at 0, so the stale partial sum is
      // overwritten by the first enabled sample rather than cleared here.
      if (s1_en) begin
        acc  <= (cnt == '0) ? W'(s1_sum) : acc + W'(s1_sum);
        cnt  <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        dump <= (cnt == CNT_LAST);
      end else begin
        cnt  <= '0;
        dump <= 1'b0;
      end
      s3_valid <= dump;
      s3_data  <= sat_data;
      s3_user  <= sat_user;
    end
  end

  // Entry 0 is the head and drives the outputs directly from flops.
  logic [16:0] q [4];
  logic [2:0]  count;
  logic [2:0]  wr_idx;
  logic        pop;
  logic        accept;
  logic        drop;

  always_comb begin
    pop    = (count != 3'd0) && m_tready;
    accept = s3_valid && ((count != 3'd4) || pop);
    drop   = s3_valid && (count == 3'd4) && !pop;
    wr_idx = pop ? count - 3'd1 : count;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < 4; i++) q[i] <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (accept && wr_idx == 3'(i)) q[i] <= {s3_user, s3_data};
        else if (pop)                  q[i] <= q[i+1];
      end
      if (accept && wr_idx == 3'd3) q[3] <= {s3_user, s3_data};
      count <= count + {2'b00, accept} - {2'b00, pop};
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  assign m_tdata  = q[0][15:0];
  assign m_tuser  = q[0][16];
  assign m_tvalid = (count != 3'd0);

endmodule
